// File: rtl/pcs_rx_lfs_if.sv
// Receive-side link fault monitor bus: decoded XGMII in, squashed XGMII and fault status out.
// xgmii words are {ena, ctrl[3:0], data[31:0]} with lane 0 in data[7:0]/ctrl[0].
interface pcs_rx_lfs_if #(
    parameter int CNT_W = 16
);
    logic             pma_sync;
    logic [36:0]      xgmii_rx;
    logic [36:0]      xgmii_out;
    logic [1:0]       link_fault;
    logic [CNT_W-1:0] fault_cnt;

    modport master (
        output pma_sync, xgmii_rx,
        input  xgmii_out, link_fault, fault_cnt
    );

    modport slave (
        input  pma_sync, xgmii_rx,
        output xgmii_out, link_fault, fault_cnt
    );
endinterface

// File: rtl/pcs_rx_lfs.sv
// Reconciliation-sublayer link fault monitor: detects Local/Remote Fault ordered sets,
// runs the link-fault state machine and replaces faulted receive data with Idle.
module pcs_rx_lfs #(
    parameter int COL_WIN = 128,
    parameter int SEQ_THR = 4,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pcs_rx_lfs_if.slave  lfs
);
    localparam int COL_W = $clog2(COL_WIN + 1);
    localparam int SEQ_W = $clog2(SEQ_THR + 1);

    localparam logic [1:0]  LF_OK    = 2'b00;
    localparam logic [1:0]  LF_LOCAL = 2'b01;
    localparam logic [36:0] IDLE_COL = {1'b1, 4'hF, 32'h0707_0707};

    typedef enum logic [1:0] {S_OK, S_CNT, S_FAULT} state_t;

    state_t           state;
    logic [1:0]       link_fault;
    logic [1:0]       last_t;
    logic [SEQ_W-1:0] seq_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [CNT_W-1:0] fault_cnt;
    logic [36:0]      xgmii_p1;

    logic             vld_p0;
    logic [1:0]       seq_t_p0;
    logic             seq_p0;
    logic             win_end_p0;
    logic             thr_hit_p0;
    logic             fault_rise_p0;

    // Stage p0: ordered-set decode of the incoming column
    assign vld_p0 = lfs.xgmii_rx[36];

    always_comb begin
        seq_t_p0 = LF_OK;
        if (lfs.xgmii_rx[35:32] == 4'b0001 && lfs.xgmii_rx[7:0] == 8'h9C &&
            lfs.xgmii_rx[23:8] == 16'h0000) begin
            if (lfs.xgmii_rx[31:24] == 8'h01)
                seq_t_p0 = 2'b01;
            else if (lfs.xgmii_rx[31:24] == 8'h02)
                seq_t_p0 = 2'b10;
        end
    end

    assign seq_p0     = (seq_t_p0 != LF_OK);
    assign win_end_p0 = (col_cnt == COL_W'(COL_WIN - 1));
    assign thr_hit_p0 = (seq_cnt == SEQ_W'(SEQ_THR - 1));

    // A fault can only be newly raised by sync loss or by the threshold sequence while counting
    assign fault_rise_p0 = (link_fault == LF_OK) &&
                           (!lfs.pma_sync ||
                            (vld_p0 && state == S_CNT && seq_p0 && seq_t_p0 == last_t && thr_hit_p0));

    // Stage p1: link-fault state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OK;
            link_fault <= LF_OK;
            last_t     <= LF_OK;
            seq_cnt    <= '0;
            col_cnt    <= '0;
        end else if (!lfs.pma_sync) begin
            state      <= S_FAULT;
            link_fault <= LF_LOCAL;
            last_t     <= LF_LOCAL;
            col_cnt    <= '0;
        end else if (vld_p0) begin
            case (state)
                S_OK: begin
                    if (seq_p0) begin
                        state   <= S_CNT;
                        last_t  <= seq_t_p0;
                        seq_cnt <= SEQ_W'(1);
                        col_cnt <= '0;
                    end
                end
                S_CNT, S_FAULT: begin
                    if (seq_p0 && seq_t_p0 == last_t) begin
                        col_cnt <= '0;
                        if (state == S_CNT) begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                            if (thr_hit_p0) begin
                                state      <= S_FAULT;
                                link_fault <= seq_t_p0;
                            end
                        end
                    end else if (seq_p0) begin
                        // A different fault type restarts the run; the old status is kept meanwhile
                        state   <= S_CNT;
                        last_t  <= seq_t_p0;
                        seq_cnt <= SEQ_W'(1);
                        col_cnt <= '0;
                    end else if (win_end_p0) begin
                        state      <= S_OK;
                        link_fault <= LF_OK;
                        seq_cnt    <= '0;
                        col_cnt    <= '0;
                    end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                    end
                end
                default: state <= S_OK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_cnt <= '0;
        else if (fault_rise_p0 && fault_cnt != {CNT_W{1'b1}})
            fault_cnt <= fault_cnt + CNT_W'(1);
    end

    // Stage p1: output column, squashed to Idle while faulted or when it carries a sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xgmii_p1 <= '0;
        else if (vld_p0 && (seq_p0 || link_fault != LF_OK))
            xgmii_p1 <= IDLE_COL;
        else
            xgmii_p1 <= lfs.xgmii_rx;
    end

    assign lfs.xgmii_out  = xgmii_p1;
    assign lfs.link_fault = link_fault;
    assign lfs.fault_cnt  = fault_cnt;
endmodule

// File: tb/tb_pcs_rx_lfs.sv
// Directed plus randomized bench for pcs_rx_lfs against a run-length model of the fault rules.
module tb_pcs_rx_lfs;
    localparam int COL_WIN = 128;
    localparam int SEQ_THR = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [36:0] IDLE_COL = {1'b1, 4'hF, 32'h0707_0707};
    localparam logic [36:0] LF_COL   = {1'b1, 4'h1, 32'h0100_009C};
    localparam logic [36:0] RF_COL   = {1'b1, 4'h1, 32'h0200_009C};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcs_rx_lfs_if #(.CNT_W(CNT_W)) bus ();

    pcs_rx_lfs #(
        .COL_WIN (COL_WIN),
        .SEQ_THR (SEQ_THR),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lfs   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: a run of same-type sequences, and the gap of clean columns since the last one
    int          m_lf, m_run_t, m_run_n, m_gap, m_fcnt;
    logic [36:0] m_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int seq_type(input logic [36:0] c);
        if (c[35:32] == 4'b0001 && c[7:0] == 8'h9C && c[23:8] == 16'h0000) begin
            if (c[31:24] == 8'h01) return 1;
            if (c[31:24] == 8'h02) return 2;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_lf = 0; m_run_t = 0; m_run_n = 0; m_gap = 0; m_fcnt = 0; m_out = '0;
    endtask

    task automatic model_step(input logic ps, input logic [36:0] c);
        int old_lf;
        int t;
        old_lf = m_lf;
        t = seq_type(c);
        m_out = (c[36] && (t != 0 || m_lf != 0)) ? IDLE_COL : c;
        if (!ps) begin
            m_lf = 1; m_run_t = 1; m_run_n = SEQ_THR; m_gap = 0;
        end else if (c[36]) begin
            if (t != 0) begin
                if (m_run_n == 0 || t != m_run_t) begin
                    m_run_t = t;
                    m_run_n = 1;
                end else if (m_run_n < SEQ_THR) begin
                    m_run_n++;
                end
                m_gap = 0;
                if (m_run_n == SEQ_THR) m_lf = t;
            end else if (m_run_n > 0) begin
                m_gap++;
                if (m_gap == COL_WIN) begin
                    m_run_n = 0; m_gap = 0; m_lf = 0;
                end
            end
        end
        if (old_lf == 0 && m_lf != 0 && m_fcnt < CNT_MAX) m_fcnt++;
    endtask

    task automatic step(input logic ps, input logic [36:0] c);
        bus.pma_sync = ps;
        bus.xgmii_rx = c;
        @(posedge clk);
        #1;
        model_step(ps, c);
        chk("xgmii_out", 64'(bus.xgmii_out), 64'(m_out));
        chk("link_fault", 64'(bus.link_fault), 64'(m_lf));
        chk("fault_cnt", 64'(bus.fault_cnt), 64'(m_fcnt));
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, IDLE_COL);
    endtask

    function automatic logic [36:0] data_col();
        return {1'b1, 4'h0, 32'($urandom)};
    endfunction

    function automatic logic [36:0] rand_col();
        int r;
        logic [36:0] c;
        r = $urandom_range(0, 99);
        if (r < 35)      c = IDLE_COL;
        else if (r < 58) c = data_col();
        else if (r < 70) c = LF_COL;
        else if (r < 82) c = RF_COL;
        else if (r < 88) c = {1'b1, 4'h1, 8'($urandom_range(3, 255)), 16'h0000, 8'h9C};
        else if (r < 92) c = {1'b1, 4'h1, 8'h01, 16'($urandom_range(1, 65535)), 8'h9C};
        else             c = {1'b0, 36'($urandom)} | ($urandom_range(0, 1) != 0 ? 37'(LF_COL & 37'h0F_FFFF_FFFF) : 37'h0);
        return c;
    endfunction

    initial begin
        logic [36:0] col;
        logic        saw_fault;

        // Power-on reset
        bus.pma_sync = 1'b1;
        bus.xgmii_rx = '0;
        model_reset();
        #1;
        chk("por_xgmii_out", 64'(bus.xgmii_out), 64'h0);
        chk("por_link_fault", 64'(bus.link_fault), 64'h0);
        chk("por_fault_cnt", 64'(bus.fault_cnt), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idles(5);

        // T2: Local Fault declared by four LF columns spaced 10 idles apart
        for (int k = 0; k < 4; k++) begin
            step(1'b1, LF_COL);
            chk("t2_lf_squashed", 64'(bus.xgmii_out), 64'(IDLE_COL));
            if (k < 3) begin
                chk("t2_not_yet", 64'(bus.link_fault), 64'h0);
                idles(10);
            end
        end
        chk("t2_link_fault", 64'(bus.link_fault), 64'h1);
        chk("t2_fault_cnt", 64'(bus.fault_cnt), 64'h1);

        // T3: clear after 128 valid idles; ena=0 beats do not count
        for (int i = 0; i < 127; i++) begin
            if (i % 16 == 5) step(1'b1, {1'b0, 36'($urandom)});
            if (i % 40 == 7) step(1'b1, LF_COL & 37'h0F_FFFF_FFFF);
            step(1'b1, IDLE_COL);
        end
        chk("t3_hold_127", 64'(bus.link_fault), 64'h1);
        step(1'b1, IDLE_COL);
        chk("t3_clear_128", 64'(bus.link_fault), 64'h0);

        // T4: mixed run, then a direct Remote -> Local switch
        for (int k = 0; k < 3; k++) step(1'b1, LF_COL);
        for (int k = 0; k < 4; k++) step(1'b1, RF_COL);
        chk("t4_remote", 64'(bus.link_fault), 64'h2);
        chk("t4_cnt", 64'(bus.fault_cnt), 64'h2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, LF_COL);
            chk("t4_hold_remote", 64'(bus.link_fault), 64'h2);
        end
        step(1'b1, LF_COL);
        chk("t4_local", 64'(bus.link_fault), 64'h1);
        chk("t4_cnt_same", 64'(bus.fault_cnt), 64'h2);
        idles(COL_WIN);
        chk("t4_cleared", 64'(bus.link_fault), 64'h0);

        // T5: sequences too far apart never declare a fault
        saw_fault = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, LF_COL);
            if (bus.link_fault != 2'b00) saw_fault = 1'b1;
            for (int i = 0; i < COL_WIN; i++) begin
                step(1'b1, IDLE_COL);
                if (bus.link_fault != 2'b00) saw_fault = 1'b1;
            end
        end
        chk("t5_never_fault", 64'(saw_fault), 64'h0);

        // T6: sync loss during a frame
        step(1'b1, {1'b1, 4'h1, 32'hD555_55FB});
        for (int k = 0; k < 3; k++) begin
            col = data_col();
            step(1'b1, col);
            chk("t6_data_pass", 64'(bus.xgmii_out), 64'(col));
        end
        step(1'b0, data_col());
        chk("t6_sync_lf", 64'(bus.link_fault), 64'h1);
        chk("t6_sync_cnt", 64'(bus.fault_cnt), 64'h3);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, data_col());
            chk("t6_data_idle", 64'(bus.xgmii_out), 64'(IDLE_COL));
        end
        step(1'b1, {1'b1, 4'hF, 32'h0707_07FD});
        idles(COL_WIN - 5);
        chk("t6_hold", 64'(bus.link_fault), 64'h1);
        step(1'b1, IDLE_COL);
        chk("t6_clear", 64'(bus.link_fault), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, rand_col());

        // T1: reset asserted mid-stream clears outputs at once
        bus.xgmii_rx = LF_COL;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("t1_xgmii_out", 64'(bus.xgmii_out), 64'h0);
        chk("t1_link_fault", 64'(bus.link_fault), 64'h0);
        chk("t1_fault_cnt", 64'(bus.fault_cnt), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idles(20);
        chk("t1_stays_ok", 64'(bus.link_fault), 64'h0);

        // Counter saturation through repeated sync losses
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            step(1'b0, IDLE_COL);
            idles(COL_WIN);
        end
        chk("sat_fault_cnt", 64'(bus.fault_cnt), 64'(CNT_MAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
